mcp_spi_master: RTL and testbench
=================================

MCP_SPI_MASTER -- requirements
Module: mcp_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SPI half-period in sysClk cycles; legal range 4..255.
REQ-002 Parameter DEV_ADDR, default 3'b000: device hardware address placed in opcode bits [3:1].
REQ-003 sysClk  in  1  system clock; sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_i  in  1  transaction request; sampled only in IDLE.
REQ-006 rw_i  in  1  1=read, 0=write; captured at accept.
REQ-007 reg_addr_i  in  8  target register address; captured at accept.
REQ-008 wr_data_i  in  8  write data byte; captured at accept.
REQ-009 busy_o  out  1  high from the cycle after accept until return to IDLE.
REQ-010 done_o  out  1  one-cycle pulse at transaction completion.
REQ-011 rd_data_o  out  8  third byte received on a read.
REQ-012 spiClk_o  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 cs_o  out  1  active-low chip select.
REQ-014 mosi_o  out  1  serial data to slave, MSB first.
REQ-015 miso_i  in  1  serial data from slave.

Function
REQ-016 Transaction = 3 bytes, MSB first: opcode {4'b0100, DEV_ADDR, rw}, reg_addr, data (wr_data on write, 8'h00 on read).
REQ-017 States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP; all registered outputs.
REQ-018 IDLE: req_i=1 accepts; next cycle enters SETUP with cs_o=0, mosi_o=opcode bit 7, busy_o=1.
REQ-019 SETUP lasts CLK_DIV cycles, then SHIFT_HI (spiClk_o=1).
REQ-020 SHIFT_HI/SHIFT_LO each last CLK_DIV cycles; 24 rising and 24 falling spiClk_o edges per transaction.
REQ-021 MISO sampled into the receive shift register on the sysClk edge at which spiClk_o rises.
REQ-022 MOSI advances to the next bit on the sysClk edge at which spiClk_o falls; never changes while spiClk_o=1.
REQ-023 Bit counter 7..0, byte counter 0..2; after the 24th falling edge enter HOLD; no extra inter-byte gap.
REQ-024 HOLD lasts CLK_DIV cycles with spiClk_o=0, cs_o=0; on exit cs_o=1 and done_o=1 in the same cycle.
REQ-025 On a read, rd_data_o updates with the third received byte in the done_o cycle; on a write rd_data_o holds its value.
REQ-026 GAP lasts CLK_DIV cycles (cs_o=1, busy_o=1), then IDLE; busy_o=0 in IDLE.
REQ-027 cs_o low duration per transaction = 50*CLK_DIV sysClk cycles exactly.
REQ-028 req_i while busy_o=1 is ignored, not queued; req_i held high starts a new transaction from IDLE.
REQ-029 Inputs rw_i/reg_addr_i/wr_data_i may change after accept without effect.

Reset
REQ-030 reset=1 forces in the next cycle: IDLE, cs_o=1, spiClk_o=0, mosi_o=0, busy_o=0, done_o=0, rd_data_o=8'h00, counters 0.
REQ-031 Reset mid-transaction aborts without done_o and without updating rd_data_o; reset has priority over req_i.

Structure
REQ-032 Shared package spi_master_pkg holds the MasterState typedef and opcode prefix constant 4'b0100.
REQ-033 One sub-module SpiClkGen: CLK_DIV down-counter producing a one-cycle half-period tick, cleared on reset and on accept.

Verification
REQ-034 CLK_DIV=4, write addr 8'h0A data 8'h55 -> MOSI bytes 8'h40,8'h0A,8'h55; 24 spiClk_o rises; cs_o low 200 cycles; one done_o pulse.
REQ-035 Read addr 8'h0A, slave model returns 8'h28 in byte 3 -> opcode 8'h41; rd_data_o=8'h28 at done_o.
REQ-036 DEV_ADDR=3'b101, read -> opcode 8'h4B.
REQ-037 req_i pulsed 3 times during busy_o -> exactly one transaction, one done_o.
REQ-038 reset asserted after byte 1 -> next cycle cs_o=1, spiClk_o=0, busy_o=0, no done_o; following write completes correctly.
REQ-039 req_i held high two transactions -> cs_o high >=4 cycles between them; MOSI stable whenever spiClk_o=1.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the MCP-style SPI register master.
//   MasterState   : transaction sequencer states
//   OPCODE_PREFIX : fixed upper nibble of the opcode byte
//   build_opcode  : assembles {prefix, device address, rw}
package spi_master_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned DIV_W      = 8;

  localparam logic [3:0] OPCODE_PREFIX = 4'b0100;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } MasterState;

  // Opcode byte: prefix, hardware address, read/write flag (1 = read).
  function automatic logic [7:0] build_opcode(input logic [2:0] dev_addr, input logic rw);
    return {OPCODE_PREFIX, dev_addr, rw};
  endfunction

endpackage

// File: rtl/SpiClkGen.sv
// Half-period timebase for the SPI master.
//   sysClk : system clock
//   reset  : synchronous active-high reset
//   clear  : restart the period (asserted on transaction accept)
//   tick_c : high for one cycle every CLK_DIV cycles, first tick CLK_DIV
//            cycles after clear
module SpiClkGen
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic sysClk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Down-counter; reload on reset, clear, or terminal count.
  always_ff @(posedge sysClk) begin
    if (reset || clear) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/mcp_spi_master.sv
// SPI mode-0 master issuing 3-byte register transactions
// ({opcode, reg_addr, data}) to an MCP-style device.
//   sysClk, reset           : clock and synchronous active-high reset
//   req_i, rw_i             : request and direction (1 = read), taken in IDLE
//   reg_addr_i, wr_data_i   : register address and write byte, taken at accept
//   busy_o, done_o          : in-progress flag and completion pulse
//   rd_data_o               : third byte received on a read
//   spiClk_o, cs_o, mosi_o  : SPI clock, active-low select, serial out
//   miso_i                  : serial in
module mcp_spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [2:0]  DEV_ADDR = 3'b000
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wr_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rd_data_o,
  output logic       spiClk_o,
  output logic       cs_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  MasterState            state;
  logic [2:0]            bit_cnt;
  logic [1:0]            byte_cnt;
  logic [FRAME_BITS-2:0] tx_sr;     // bits still to send after the one on mosi_o
  logic [7:0]            rx_sr;
  logic                  rw_q;

  logic                  accept_c;
  logic                  tick_c;
  logic                  last_bit_c;
  logic [FRAME_BITS-1:0] frame_c;

  assign accept_c   = (state == IDLE) && req_i;
  assign last_bit_c = (bit_cnt == 3'd0) && (byte_cnt == 2'd2);
  assign frame_c    = {build_opcode(DEV_ADDR, rw_i), reg_addr_i, (rw_i ? 8'h00 : wr_data_i)};

  SpiClkGen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .sysClk (sysClk),
    .reset  (reset),
    .clear  (accept_c),
    .tick_c (tick_c)
  );

  // Transaction sequencer. Every phase lasts one tick period; spiClk_o rises
  // entering SHIFT_HI (MISO sampled) and falls entering SHIFT_LO (MOSI advances).
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state     <= IDLE;
      cs_o      <= 1'b1;
      spiClk_o  <= 1'b0;
      mosi_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rd_data_o <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      tx_sr     <= '0;
      rx_sr     <= 8'h00;
      rw_q      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            mosi_o   <= frame_c[FRAME_BITS-1];
            tx_sr    <= frame_c[FRAME_BITS-2:0];
            rw_q     <= rw_i;
            cs_o     <= 1'b0;
            busy_o   <= 1'b1;
            bit_cnt  <= 3'd7;
            byte_cnt <= 2'd0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (tick_c) begin
            spiClk_o <= 1'b1;
            rx_sr    <= {rx_sr[6:0], miso_i};
            state    <= SHIFT_HI;
          end
        end

        SHIFT_HI: begin
          if (tick_c) begin
            spiClk_o <= 1'b0;
            mosi_o   <= tx_sr[FRAME_BITS-2];
            tx_sr    <= {tx_sr[FRAME_BITS-3:0], 1'b0};
            state    <= SHIFT_LO;
          end
        end

        // End of a bit cell: either start the next bit or wind down.
        SHIFT_LO: begin
          if (tick_c) begin
            if (last_bit_c) begin
              state <= HOLD;
            end else begin
              if (bit_cnt == 3'd0) begin
                bit_cnt  <= 3'd7;
                byte_cnt <= byte_cnt + 2'd1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
              spiClk_o <= 1'b1;
              rx_sr    <= {rx_sr[6:0], miso_i};
              state    <= SHIFT_HI;
            end
          end
        end

        // rx_sr holds the last byte shifted in, i.e. the data byte of a read.
        HOLD: begin
          if (tick_c) begin
            cs_o   <= 1'b1;
            done_o <= 1'b1;
            if (rw_q) begin
              rd_data_o <= rx_sr;
            end
            state <= GAP;
          end
        end

        GAP: begin
          if (tick_c) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_spi_master.sv
// Randomized self-checking bench for mcp_spi_master. Two instances (device
// address 000 and 101) share all inputs; a slave model answers on MISO and a
// bus monitor rebuilds each frame from MOSI for comparison with the expected
// {opcode, address, data} bytes.
module tb_mcp_spi_master;

  localparam int unsigned DIV = 4;

  logic       sysClk = 1'b0;
  logic       reset  = 1'b1;
  logic       req    = 1'b0;
  logic       rw     = 1'b0;
  logic [7:0] addr   = 8'h00;
  logic [7:0] wdata  = 8'h00;
  logic       miso   = 1'b0;

  logic [1:0] sclk, cs, mosi, done, busy;
  logic [7:0] rd0, rd5;

  always #5 sysClk = ~sysClk;

  mcp_spi_master #(.CLK_DIV(DIV), .DEV_ADDR(3'b000)) dut0 (
    .sysClk(sysClk), .reset(reset), .req_i(req), .rw_i(rw), .reg_addr_i(addr),
    .wr_data_i(wdata), .busy_o(busy[0]), .done_o(done[0]), .rd_data_o(rd0),
    .spiClk_o(sclk[0]), .cs_o(cs[0]), .mosi_o(mosi[0]), .miso_i(miso));

  mcp_spi_master #(.CLK_DIV(DIV), .DEV_ADDR(3'b101)) dut5 (
    .sysClk(sysClk), .reset(reset), .req_i(req), .rw_i(rw), .reg_addr_i(addr),
    .wr_data_i(wdata), .busy_o(busy[1]), .done_o(done[1]), .rd_data_o(rd5),
    .spiClk_o(sclk[1]), .cs_o(cs[1]), .mosi_o(mosi[1]), .miso_i(miso));

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor state, per instance.
  int          rises  [2] = '{0, 0};
  int          falls  [2] = '{0, 0};
  int          cslow  [2] = '{0, 0};
  int          dones  [2] = '{0, 0};
  int          starts [2] = '{0, 0};
  int          gap    [2] = '{0, 0};
  int          last_gap [2] = '{0, 0};
  int          viol   [2] = '{0, 0};
  logic [23:0] shreg  [2] = '{24'h0, 24'h0};
  logic [23:0] last_frame [2] = '{24'h0, 24'h0};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        prev_cs   [2] = '{1'b1, 1'b1};
  logic        prev_mosi [2] = '{1'b0, 1'b0};

  // Slave response frame and bit index.
  logic [23:0] resp = 24'h0;
  int          sidx = 0;

  logic [7:0]  exp_rd = 8'h00;

  // Bus monitor and slave model, sampled mid-cycle.
  always @(negedge sysClk) begin
    if (prev_cs[0] === 1'b1 && cs[0] === 1'b0) begin
      sidx <= 0;
      miso <= resp[23];
    end else if (cs[0] === 1'b0 && prev_sclk[0] === 1'b1 && sclk[0] === 1'b0) begin
      sidx <= sidx + 1;
      if (sidx < 23) miso <= resp[22 - sidx];
    end

    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] === 1'b1 && cs[i] === 1'b0) begin
        rises[i]    <= 0;
        falls[i]    <= 0;
        shreg[i]    <= 24'h0;
        cslow[i]    <= 1;
        starts[i]   <= starts[i] + 1;
        last_gap[i] <= gap[i];
        gap[i]      <= 0;
      end else begin
        if (prev_sclk[i] === 1'b0 && sclk[i] === 1'b1) begin
          rises[i] <= rises[i] + 1;
          shreg[i] <= {shreg[i][22:0], mosi[i]};
        end
        if (prev_sclk[i] === 1'b1 && sclk[i] === 1'b0) falls[i] <= falls[i] + 1;
        if (cs[i] === 1'b0) cslow[i] <= cslow[i] + 1;
        if (cs[i] === 1'b1) gap[i] <= gap[i] + 1;
      end
      if (prev_cs[i] === 1'b0 && cs[i] === 1'b1) last_frame[i] <= shreg[i];
      if (prev_sclk[i] === 1'b1 && sclk[i] === 1'b1 && mosi[i] !== prev_mosi[i])
        viol[i] <= viol[i] + 1;
      if (done[i] === 1'b1) dones[i] <= dones[i] + 1;
      prev_sclk[i] <= sclk[i];
      prev_cs[i]   <= cs[i];
      prev_mosi[i] <= mosi[i];
    end
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_frame(input logic [2:0] dev, input logic r,
                                            input logic [7:0] a, input logic [7:0] d);
    logic [7:0] opc;
    opc = 8'h40 | (8'(dev) << 1) | 8'(r);
    return {opc, a, (r ? 8'h00 : d)};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy[0] !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check_val("idle_reached", 32'(busy[0]), 32'd0);
    tick();
  endtask

  // One complete transaction with full checking of frame, timing and result.
  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] b3);
    int n;
    int d0;
    resp  = {8'($urandom), 8'($urandom), b3};
    d0    = dones[0];
    rw    = r;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    tick();
    req   = 1'b0;
    rw    = 1'($urandom);
    addr  = 8'($urandom);
    wdata = 8'($urandom);
    check_val("busy_after_accept", 32'(busy[0]), 32'd1);
    n = 0;
    while (done[0] !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check_val("done_seen", 32'(done[0]), 32'd1);
    check_val("done_dev5", 32'(done[1]), 32'd1);
    if (r) exp_rd = b3;
    check_val("rd_data_dev0", 32'(rd0), 32'(exp_rd));
    check_val("rd_data_dev5", 32'(rd5), 32'(exp_rd));
    tick();
    check_val("done_one_cycle", 32'(done[0]), 32'd0);
    wait_idle();
    check_val("frame_dev0", 32'(last_frame[0]), 32'(exp_frame(3'b000, r, a, d)));
    check_val("frame_dev5", 32'(last_frame[1]), 32'(exp_frame(3'b101, r, a, d)));
    check_val("sclk_rises", 32'(rises[0]), 32'd24);
    check_val("sclk_falls", 32'(falls[0]), 32'd24);
    check_val("cs_low_cycles", 32'(cslow[0]), 32'(50 * DIV));
    check_val("done_count", 32'(dones[0] - d0), 32'd1);
  endtask

  initial begin
    int n;
    int s0;
    int d0;
    int seen;

    // Reset state.
    reset = 1'b1;
    repeat (3) tick();
    check_val("rst_cs", 32'(cs[0]), 32'd1);
    check_val("rst_sclk", 32'(sclk[0]), 32'd0);
    check_val("rst_mosi", 32'(mosi[0]), 32'd0);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    check_val("rst_done", 32'(done[0]), 32'd0);
    check_val("rst_rd", 32'(rd0), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Directed write and reads.
    run_txn(1'b0, 8'h0A, 8'h55, 8'h00);
    run_txn(1'b1, 8'h0A, 8'h00, 8'h28);

    // Randomized transactions.
    for (int k = 0; k < 8; k++) begin
      run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    // Requests during busy are dropped.
    s0    = starts[0];
    d0    = dones[0];
    resp  = 24'h0;
    rw    = 1'b0;
    addr  = 8'h11;
    wdata = 8'h22;
    req   = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (30 + 20 * k) tick();
      req = 1'b1;
      tick();
      req = 1'b0;
    end
    wait_idle();
    repeat (10) tick();
    check_val("busy_req_starts", 32'(starts[0] - s0), 32'd1);
    check_val("busy_req_dones", 32'(dones[0] - d0), 32'd1);
    check_val("busy_req_frame", 32'(last_frame[0]), 32'(exp_frame(3'b000, 1'b0, 8'h11, 8'h22)));

    // Read with a known result, then reset after the first byte.
    run_txn(1'b1, 8'h33, 8'h00, 8'hA7);
    d0   = dones[0];
    resp = 24'hFFFFFF;
    rw   = 1'b1;
    addr = 8'h44;
    req  = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (falls[0] < 8 && n < 500) begin
      tick();
      n++;
    end
    check_val("reached_byte2", 32'(falls[0] >= 8), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rd = 8'h00;
    check_val("abort_cs", 32'(cs[0]), 32'd1);
    check_val("abort_sclk", 32'(sclk[0]), 32'd0);
    check_val("abort_busy", 32'(busy[0]), 32'd0);
    check_val("abort_done", 32'(done[0]), 32'd0);
    check_val("abort_rd", 32'(rd0), 32'd0);
    repeat (20) tick();
    check_val("abort_no_done", 32'(dones[0] - d0), 32'd0);
    check_val("abort_cs_idle", 32'(cs[0]), 32'd1);
    run_txn(1'b0, 8'h5A, 8'hC3, 8'h00);

    // req held high across two back-to-back reads.
    s0    = starts[0];
    d0    = dones[0];
    resp  = {8'h00, 8'h00, 8'h6E};
    rw    = 1'b1;
    addr  = 8'h07;
    wdata = 8'h00;
    req   = 1'b1;
    seen  = 0;
    n     = 0;
    while (seen < 2 && n < 2000) begin
      tick();
      if (done[0] === 1'b1) seen++;
      n++;
    end
    req = 1'b0;
    exp_rd = 8'h6E;
    check_val("held_two_dones", 32'(seen), 32'd2);
    check_val("held_rd", 32'(rd0), 32'(exp_rd));
    wait_idle();
    repeat (10) tick();
    check_val("held_starts", 32'(starts[0] - s0), 32'd2);
    check_val("held_done_count", 32'(dones[0] - d0), 32'd2);
    check_val("held_cs_gap_min4", 32'(last_gap[0] >= 4), 32'd1);
    check_val("held_frame", 32'(last_frame[0]), 32'(exp_frame(3'b000, 1'b1, 8'h07, 8'h00)));
    check_val("mosi_stable_dev0", 32'(viol[0]), 32'd0);
    check_val("mosi_stable_dev5", 32'(viol[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
